// File: rtl/adc_align_pkg.sv
// adc_align_pkg: shared FSM state type and default alignment constants.
// Used by adc_chan_align and adc_lane_align.
// Optional feature macro: ADC_ALIGN_RELOCK_EN (uses RELOCK_MISS).
package adc_align_pkg;
  typedef enum logic [2:0] {IDLE, SETTLE, CHECK, SLIP, LOCKED, FAIL} state_t;
  localparam logic [3:0] TRAIN_PAT_DEF = 4'b1100;
  localparam int SETTLE_CYC_DEF = 8;
  localparam int MATCH_CYC_DEF = 16;
  localparam int MAX_SLIPS_DEF = 8;
  localparam int RELOCK_MISS = 4;
endpackage

// File: rtl/adc_chan_align.sv
// adc_chan_align: one channel's word-alignment FSM and counters.
// Ports: clk, rst (async, active high), train_start (restart pulse),
//   data (LANES*GEAR gearbox word), alignwd (slip pulse),
//   locked and fail (registered status flags).
// Macro ADC_ALIGN_RELOCK_EN: LOCKED drops back to CHECK after
//   RELOCK_MISS consecutive mismatches.
module adc_chan_align import adc_align_pkg::*; #(
  parameter int LANES = 8,
  parameter int GEAR = 4,
  parameter logic [GEAR-1:0] TRAIN_PAT = GEAR'(TRAIN_PAT_DEF),
  parameter int SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int MATCH_CYC = MATCH_CYC_DEF,
  parameter int MAX_SLIPS = MAX_SLIPS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  train_start,
  input  logic [LANES*GEAR-1:0] data,
  output logic                  alignwd,
  output logic                  locked,
  output logic                  fail
);
  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam int MW = $clog2(MATCH_CYC + 1);
  localparam int LW = $clog2(MAX_SLIPS + 1);
  state_t state;
  logic [SW-1:0] settle_cnt;
  logic [MW-1:0] match_cnt;
  logic [LW-1:0] slip_cnt;
  logic match;
  logic can_slip;
`ifdef ADC_ALIGN_RELOCK_EN
  localparam int XW = $clog2(RELOCK_MISS + 1);
  logic [XW-1:0] miss_cnt;
`endif
  always_comb begin
    match = 1'b1;
    for (int l = 0; l < LANES; l++) match = match & (data[l*GEAR +: GEAR] == TRAIN_PAT);
  end
  assign can_slip = slip_cnt < LW'(MAX_SLIPS);
  // alignwd is set on the edge entering SLIP so it coincides with the SLIP
  // cycle; locked/fail follow the state one cycle later but drop at once on
  // a restart.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      settle_cnt <= '0;
      match_cnt <= '0;
      slip_cnt <= '0;
      alignwd <= 1'b0;
      locked <= 1'b0;
      fail <= 1'b0;
`ifdef ADC_ALIGN_RELOCK_EN
      miss_cnt <= '0;
`endif
    end else begin
      alignwd <= 1'b0;
      locked <= state == LOCKED && !train_start;
      fail <= state == FAIL && !train_start;
      if (train_start) begin
        state <= SETTLE;
        settle_cnt <= '0;
        match_cnt <= '0;
        slip_cnt <= '0;
`ifdef ADC_ALIGN_RELOCK_EN
        miss_cnt <= '0;
`endif
      end else begin
        case (state)
          SETTLE:
            if (settle_cnt == SW'(SETTLE_CYC - 1)) begin
              state <= CHECK;
              match_cnt <= '0;
            end else settle_cnt <= settle_cnt + 1'b1;
          CHECK:
            if (!match) begin
              state <= can_slip ? SLIP : FAIL;
              alignwd <= can_slip;
            end else begin
              match_cnt <= match_cnt + MW'(match_cnt != MW'(MATCH_CYC));
              if (match_cnt == MW'(MATCH_CYC - 1)) state <= LOCKED;
            end
          SLIP: begin
            state <= SETTLE;
            settle_cnt <= '0;
            slip_cnt <= slip_cnt + LW'(slip_cnt != LW'(MAX_SLIPS));
          end
`ifdef ADC_ALIGN_RELOCK_EN
          LOCKED:
            if (match) miss_cnt <= '0;
            else if (miss_cnt == XW'(RELOCK_MISS - 1)) begin
              state <= CHECK;
              match_cnt <= '0;
              miss_cnt <= '0;
            end else miss_cnt <= miss_cnt + 1'b1;
`endif
          default: ;
        endcase
      end
    end
endmodule

// File: rtl/adc_lane_align.sv
// adc_lane_align: per-channel ADC lane word alignment with registered sample path.
// Ports: i_clk, i_rst (async, active high), i_train_start (restart pulse),
//   i_rx_data (chan c, lane l, bit g at c*LANES*GEAR + l*GEAR + g),
//   o_alignwd (per-channel slip pulse), o_sample (i_rx_data delayed 1 cycle),
//   o_locked, o_fail (per-channel status).
// Macro ADC_ALIGN_RELOCK_EN enables relock from LOCKED on sustained mismatch.
module adc_lane_align import adc_align_pkg::*; #(
  parameter int NUM_CHAN = 2,
  parameter int LANES = 8,
  parameter int GEAR = 4,
  parameter logic [GEAR-1:0] TRAIN_PAT = GEAR'(TRAIN_PAT_DEF),
  parameter int SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int MATCH_CYC = MATCH_CYC_DEF,
  parameter int MAX_SLIPS = MAX_SLIPS_DEF
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_train_start,
  input  logic [NUM_CHAN*LANES*GEAR-1:0] i_rx_data,
  output logic [NUM_CHAN-1:0]            o_alignwd,
  output logic [NUM_CHAN*LANES*GEAR-1:0] o_sample,
  output logic [NUM_CHAN-1:0]            o_locked,
  output logic [NUM_CHAN-1:0]            o_fail
);
  localparam int CW = LANES * GEAR;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) o_sample <= '0;
    else o_sample <= i_rx_data;
  for (genvar c = 0; c < NUM_CHAN; c++) begin : g_chan
    adc_chan_align #(
      .LANES(LANES), .GEAR(GEAR), .TRAIN_PAT(TRAIN_PAT),
      .SETTLE_CYC(SETTLE_CYC), .MATCH_CYC(MATCH_CYC), .MAX_SLIPS(MAX_SLIPS)
    ) u_chan (
      .clk(i_clk),
      .rst(i_rst),
      .train_start(i_train_start),
      .data(i_rx_data[c*CW +: CW]),
      .alignwd(o_alignwd[c]),
      .locked(o_locked[c]),
      .fail(o_fail[c])
    );
  end
endmodule

// File: tb/tb_adc_lane_align.sv
// tb_adc_lane_align: randomized self-checking bench with a closed-form timing model.
module tb_adc_lane_align;
  localparam int NC = 2, L = 8, G = 4, CW = L * G, W = NC * CW;
  localparam int SET = 8, MAT = 16, MAXS = 8, CS = 60, NCYC = 100;
  localparam logic [G-1:0] PAT = 4'b1100;
  logic clk = 1'b0;
  logic rst, start;
  logic [W-1:0] rx, sample;
  logic [NC-1:0] alignwd, locked, fail;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  adc_lane_align dut (
    .i_clk(clk), .i_rst(rst), .i_train_start(start), .i_rx_data(rx),
    .o_alignwd(alignwd), .o_sample(sample), .o_locked(locked), .o_fail(fail)
  );
  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [G-1:0] rotl(input logic [G-1:0] p, input int o);
    logic [2*G-1:0] t;
    t = {p, p} << o;
    return t[2*G-1:G];
  endfunction
  // kind 0: pattern, with masked lanes rotated by off; 4: all zero; 5: random
  function automatic logic [CW-1:0] chan_data(input int kind, input int off, input logic [L-1:0] mask);
    logic [CW-1:0] d;
    for (int l = 0; l < L; l++) d[l*G +: G] = mask[l] ? rotl(PAT, off) : PAT;
    if (kind == 4) d = '0;
    else if (kind == 5) d = CW'($urandom);
    return d;
  endfunction
  // k < 4: lanes need k slips to align; k >= 4: never aligns.
  // Pulse j lands at cycle (SET+2)*(j+1); lock at 2+SET+MAT+(SET+2)*k;
  // failure at (SET+2)*(MAXS+1)+1, counted from the start pulse in cycle 0.
  task automatic run(input int k0, input int k1, input int corrupt_len);
    int k[NC];
    int slips[NC];
    logic [L-1:0] mask[NC];
    logic [W-1:0] prev;
    k[0] = k0;
    k[1] = k1;
    for (int c = 0; c < NC; c++) begin
      slips[c] = 0;
      mask[c] = L'($urandom) | L'(1);
    end
    prev = rx;
    for (int n = 0; n < NCYC; n++) begin
      @(negedge clk);
      check($sformatf("sample n%0d", n), sample, prev);
      for (int c = 0; c < NC; c++) begin
        bit fails;
        int np, lk;
        bit pexp, lexp, fexp;
        fails = k[c] >= 4;
        np = fails ? MAXS : k[c];
        pexp = n >= SET + 2 && n % (SET + 2) == 0 && n / (SET + 2) <= np;
        check($sformatf("alignwd%0d n%0d", c, n), W'(alignwd[c]), W'(pexp));
        if (n > 0) begin
          lk = 2 + SET + MAT + (SET + 2) * k[c];
          lexp = !fails && n >= lk;
`ifdef ADC_ALIGN_RELOCK_EN
          if (corrupt_len >= 4 && n >= CS + 5 && n <= CS + 4 + MAT) lexp = 1'b0;
`endif
          fexp = fails && n >= (SET + 2) * (MAXS + 1) + 1;
          check($sformatf("locked%0d n%0d", c, n), W'(locked[c]), W'(lexp));
          check($sformatf("fail%0d n%0d", c, n), W'(fail[c]), W'(fexp));
        end
        if (alignwd[c]) slips[c]++;
      end
      start = n == 0;
      for (int c = 0; c < NC; c++)
        rx[c*CW +: CW] = chan_data(k[c] >= 4 ? k[c] : 0, (((k[c] - slips[c]) % G) + G) % G, mask[c]);
      if (n >= CS && n < CS + corrupt_len) rx = ~rx;
      prev = rx;
    end
    start = 1'b0;
  endtask
  initial begin
    rst = 1'b1;
    start = 1'b0;
    rx = '0;
    repeat (3) @(negedge clk);
    check("rst alignwd", W'(alignwd), '0);
    check("rst locked", W'(locked), '0);
    check("rst fail", W'(fail), '0);
    check("rst sample", sample, '0);
    rst = 1'b0;
    run(0, 0, 0);
    run(2, 2, 0);
    run(4, 4, 0);
    run(0, 3, 0);
    run(0, 0, 4);
    run(0, 0, 3);
    repeat (4) run($urandom_range(0, 5), $urandom_range(0, 5), 0);
    for (int n = 0; n <= SET + 2; n++) begin
      @(negedge clk);
      start = n == 0;
      rx = {chan_data(0, 0, '0), chan_data(0, 1, '1)};
    end
    start = 1'b0;
    check("slip pulse before rst", W'(alignwd), W'(1));
    #1 rst = 1'b1;
    #1;
    check("mid-slip rst alignwd", W'(alignwd), '0);
    check("mid-slip rst locked", W'(locked), '0);
    check("mid-slip rst fail", W'(fail), '0);
    check("mid-slip rst sample", sample, '0);
    @(negedge clk);
    rst = 1'b0;
    rx = {NC{chan_data(0, 0, '0)}};
    repeat (SET + MAT + 4) @(negedge clk);
    check("idle locked", W'(locked), '0);
    check("idle alignwd", W'(alignwd), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
